// File: rtl/bp_initiator.sv
// bp_initiator: bytepipe host-side initiator turning register requests into up bytes and down bytes into responses.
// Define BP_INITIATOR_DROPCOUNT_EN to add o_nDropped (saturating count of stray dn bytes and timeouts).
module bp_initiator #(
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_EXP = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_cg,
    input  logic             i_reqValid,
    output logic             o_reqReady,
    input  logic             i_reqWrite,
    input  logic [6:0]       i_reqAddr,
    input  logic [7:0]       i_reqData,
    input  logic [LEN_W-1:0] i_reqLen,
    output logic             o_upValid,
    input  logic             i_upReady,
    output logic [7:0]       o_upData,
    input  logic             i_dnValid,
    output logic             o_dnReady,
    input  logic [7:0]       i_dnData,
    output logic             o_rspValid,
    input  logic             i_rspReady,
    output logic [7:0]       o_rspData,
    output logic             o_rspLast,
    output logic             o_rspErr,
`ifdef BP_INITIATOR_DROPCOUNT_EN
    output logic [7:0]       o_nDropped,
`endif
    output logic             o_busy
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT} state_t;
    // Timeout fires on the enabled cycle that takes the counter to 2^TIMEOUT_EXP-1.
    localparam logic [TIMEOUT_EXP-1:0] T_LAST = TIMEOUT_EXP'((1 << TIMEOUT_EXP) - 2);
    state_t state, state_nx;
    logic wr;
    logic [6:0] addr;
    logic [7:0] data;
    logic [LEN_W-1:0] len, beat;
    logic [TIMEOUT_EXP-1:0] tcnt;
    logic rsp_free, req_take, up_take, dn_take, last_beat, timeout;
    always_comb begin
        rsp_free   = !o_rspValid || i_rspReady;
        o_reqReady = i_cg && state == IDLE && rsp_free;
        o_dnReady  = i_cg && (state == IDLE || (state == WAIT && rsp_free));
        o_upValid  = state == ADDR || state == DATA;
        o_upData   = state == ADDR ? {wr, addr} : state == DATA ? data : 8'h00;
        o_busy     = state != IDLE;
        req_take   = i_reqValid && o_reqReady;
        up_take    = i_cg && o_upValid && i_upReady;
        dn_take    = i_dnValid && o_dnReady && state == WAIT;
        last_beat  = beat == len;
        timeout    = i_cg && state == WAIT && rsp_free && !dn_take && tcnt == T_LAST;
        state_nx   = state;
        if (req_take) state_nx = ADDR;
        if (up_take) state_nx = (state == ADDR && wr) ? DATA : WAIT;
        if (dn_take) state_nx = last_beat ? IDLE : ADDR;
        if (timeout) state_nx = IDLE;
    end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else if (i_cg) state <= state_nx;
    end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr         <= 1'b0;
            addr       <= '0;
            data       <= '0;
            len        <= '0;
            beat       <= '0;
            tcnt       <= '0;
            o_rspValid <= 1'b0;
            o_rspData  <= '0;
            o_rspLast  <= 1'b0;
            o_rspErr   <= 1'b0;
        end else if (i_cg) begin
            if (req_take) begin
                wr   <= i_reqWrite;
                addr <= i_reqAddr;
                data <= i_reqData;
                len  <= i_reqWrite ? '0 : i_reqLen;
                beat <= '0;
            end
            if (dn_take && !last_beat) beat <= beat + 1'b1;
            // Frozen while the response slot is held by the consumer.
            tcnt <= state != WAIT ? '0 : rsp_free ? tcnt + 1'b1 : tcnt;
            if (dn_take) {o_rspValid, o_rspData, o_rspLast, o_rspErr} <= {1'b1, i_dnData, last_beat, 1'b0};
            else if (timeout) {o_rspValid, o_rspData, o_rspLast, o_rspErr} <= {1'b1, 8'h00, 1'b1, 1'b1};
            else if (i_rspReady) o_rspValid <= 1'b0;
        end
    end
`ifdef BP_INITIATOR_DROPCOUNT_EN
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) o_nDropped <= '0;
        else if (((state == IDLE && i_dnValid && o_dnReady) || timeout) && o_nDropped != 8'hFF)
            o_nDropped <= o_nDropped + 1'b1;
    end
`endif
endmodule

// File: doc/bp_initiator.md
Name: bp_initiator

Overview:
- Bytepipe initiator: the host-side end of the bytepipe register protocol that the USB correlator devices serve as responder.
- Converts parallel register requests (single write, single read, burst read) into bytepipe address/data bytes on the up stream.
- Collects responder bytes from the down stream and returns them on a parallel response channel.
- Used in loopback benches and as the command engine of an on-chip sequencer driving a bytepipe register map.

Parameters:
- LEN_W, 8, width of burst length field; burst = i_reqLen+1 beats (1..2^LEN_W).
- TIMEOUT_EXP, 8, response timeout = 2^TIMEOUT_EXP-1 enabled cycles per beat.

Ports:
- i_clk  in  1  single clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_cg  in  1  clock gate; all state updates only when 1.
- i_reqValid  in  1  request valid.
- o_reqReady  out  1  request accepted when valid&ready.
- i_reqWrite  in  1  1=write, 0=read.
- i_reqAddr  in  7  register address.
- i_reqData  in  8  write data.
- i_reqLen  in  LEN_W  read burst beats minus 1; ignored for writes.
- o_upValid  out  1  bytepipe to responder, valid.
- i_upReady  in  1  responder ready.
- o_upData  out  8  up byte.
- i_dnValid  in  1  bytepipe from responder, valid.
- o_dnReady  out  1  initiator ready.
- i_dnData  in  8  down byte.
- o_rspValid  out  1  response valid.
- i_rspReady  in  1  response consumer ready.
- o_rspData  out  8  response byte (read value, or old value for write).
- o_rspLast  out  1  final beat of request.
- o_rspErr  out  1  beat timed out; o_rspData=0.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (i_rstn=0, async): state=IDLE, all valids 0, o_busy=0, data outputs 0, counters 0.
- Protocol:
  - Addr byte = {write, addr[6:0]}.
  - Write: addr byte, then data byte; responder returns 1 byte (old value).
  - Read beat: addr byte; responder returns 1 byte.
  - Burst of L+1: addr byte re-sent each beat, after previous response received.
- FSM states: IDLE, ADDR, DATA, WAIT.
  - IDLE: o_reqReady=1. Accept -> latch write/addr/data/len, beat counter=0, go ADDR.
  - ADDR: o_upValid=1, o_upData=addr byte. On i_upReady: write -> DATA, read -> WAIT.
  - DATA: o_upValid=1, o_upData=data. On i_upReady -> WAIT.
  - WAIT: timeout counter cleared on entry, increments per enabled cycle.
    - Accepted dn byte: load response register; last beat -> IDLE, else beat++ -> ADDR.
    - Counter reaches 2^TIMEOUT_EXP-1: load response with err=1, last=1, data=0; abort remaining beats; -> IDLE.
  - o_upValid held stable with o_upData until accepted; never drops without handshake.
- Latency:
  - Accept at cycle N -> o_upValid=1 at N+1.
  - Dn handshake at M -> o_rspValid=1 at M+1.
  - Minimum write = 2 up handshakes + 1 dn.
- Response register (1 entry):
  - o_rspValid cleared on i_rspReady.
  - o_dnReady = (state==WAIT) && (!o_rspValid || i_rspReady); i.e. consumer backpressure stalls the dn stream.
  - Timeout counter frozen while stalled by rsp backpressure.
  - Timeout response only loads when slot free.
- o_dnReady=1 in IDLE: stray dn bytes accepted and discarded (never forwarded).
- o_reqReady=0 in IDLE while o_rspValid && !i_rspReady, so the response of request K is always presented before request K+1 issues.
- i_cg=0: no state/counter/output-register change; handshakes not counted (ready outputs forced 0).
- Width: beat counter LEN_W bits, compare to latched len; no wrap (max 2^LEN_W beats).
- Async reset mid-transaction: immediate IDLE, response lost, no partial byte reissued.

Optional Feature:
- Macro BP_INITIATOR_DROPCOUNT_EN.
- Defined: adds port o_nDropped out 8.
  - Saturating count of stray dn bytes discarded in IDLE, plus timeouts.
  - Reset 0; holds at 255.
- Undefined: port absent, stray bytes silently discarded, no counter logic.

Test Plan:
- Write addr 0x05 data 0xA3, responder returns 0x11:
  - up bytes 0x85, 0xA3.
  - rsp data=0x11, last=1, err=0.
  - o_busy back to 0 one cycle after dn handshake.
- Read burst addr 0x02 len=3, responder returns 0x10..0x13:
  - up shows 0x02 four times, each after previous response.
  - rsp data 0x10, 0x11, 0x12, 0x13; last only on 0x13.
- Burst len=3 with responder silent after 2nd beat:
  - 3rd beat emits err=1, last=1, data=0 exactly 255 cycles after WAIT entry (TIMEOUT_EXP=8).
  - No 4th addr byte.
- i_upReady held 0 for 10 cycles in ADDR: o_upValid/o_upData stable throughout; i_rspReady=0 with rsp pending -> o_dnReady=0 and o_reqReady=0 until drained.
- Stray dn byte 0x7E in IDLE:
  - no o_rspValid.
  - with BP_INITIATOR_DROPCOUNT_EN, o_nDropped 0->1; 300 strays saturate at 255.
- i_rstn pulsed low in DATA: outputs zero asynchronously; next request after release executes cleanly from ADDR.
